spi_reg_ctrl: RTL and testbench

SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

---
 rtl/spi_reg_pkg.sv | 18 +
 rtl/spi_reg_addr_ctr.sv | 39 +++
 rtl/spi_reg_ctrl.sv | 126 ++++++++++++
 tb/tb_spi_reg_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register controller.
package spi_reg_pkg;

    localparam int NUM_REGS_DEF = 16;
    localparam int RW_BIT       = 7;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WR,
        RD_REQ,
        RD_WAIT,
        RD_LOAD,
        RD_HOLD,
        ERR
    } state_e;

endpackage

// File: rtl/spi_reg_addr_ctr.sv
// Register address counter: loads the frame start address, increments with wrap at NUM_REGS-1.
module spi_reg_addr_ctr
    import spi_reg_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] addr_o
);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    // NOTE: addr_d gets a default before any branch so no latch is inferred.
    always_comb begin
        addr_d = addr_q;
        if (load_i) begin
            addr_d = load_val_i;
        end else if (inc_i) begin
            addr_d = (addr_q == ADDR_W'(NUM_REGS - 1)) ? '0 : addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI command decoder driving a register bank; reads return through tx_data/tx_valid.
// Define SPI_REG_AUTOINC_EN to advance the address after every data byte (wraps to 0).
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              err
);

    state_e     state_q;
    logic [7:0] tx_data_q;
    logic [7:0] reg_wdata_q;
    logic       tx_valid_q;
    logic       reg_we_q;
    logic       reg_re_q;
    logic       err_q;

    logic       cmd_bad;
    logic       addr_load;
    logic       addr_inc;

    assign cmd_bad   = ({25'b0, rx_data[6:0]} >= 32'(NUM_REGS));
    assign addr_load = (state_q == CMD) && rx_valid && !cs_n;

`ifdef SPI_REG_AUTOINC_EN
    // Writes advance one cycle after the strobe so reg_addr still shows the written address.
    assign addr_inc = reg_we_q || ((state_q == RD_HOLD) && rx_valid && !cs_n);
`else
    assign addr_inc = 1'b0;
`endif

    spi_reg_addr_ctr #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_addr_ctr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (addr_load),
        .load_val_i (rx_data[ADDR_W-1:0]),
        .inc_i      (addr_inc),
        .addr_o     (reg_addr)
    );

    // NOTE: sequential state uses non-blocking assignments; strobes default low every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tx_data_q   <= '0;
            reg_wdata_q <= '0;
            tx_valid_q  <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            tx_valid_q <= 1'b0;
            reg_we_q   <= 1'b0;
            reg_re_q   <= 1'b0;
            if (cs_n) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= CMD;
                        err_q   <= 1'b0;
                    end
                    CMD: begin
                        if (rx_valid) begin
                            if (cmd_bad) begin
                                state_q <= ERR;
                                err_q   <= 1'b1;
                            end else if (rx_data[RW_BIT]) begin
                                state_q  <= RD_REQ;
                                reg_re_q <= 1'b1;
                            end else begin
                                state_q <= WR;
                            end
                        end
                    end
                    WR: begin
                        if (rx_valid) begin
                            reg_we_q    <= 1'b1;
                            reg_wdata_q <= rx_data;
                        end
                    end
                    RD_REQ:  state_q <= RD_WAIT;
                    RD_WAIT: begin
                        tx_data_q  <= reg_rdata;
                        tx_valid_q <= 1'b1;
                        state_q    <= RD_LOAD;
                    end
                    RD_LOAD: state_q <= RD_HOLD;
                    RD_HOLD: begin
                        if (rx_valid) begin
                            state_q  <= RD_REQ;
                            reg_re_q <= 1'b1;
                        end
                    end
                    ERR:     state_q <= ERR;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_we    = reg_we_q;
    assign reg_re    = reg_re_q;
    assign err       = err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: frame-level reference model compared against observed strobes.
module tb_spi_reg_ctrl;

    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = 4;
`ifdef SPI_REG_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  a;
        logic [7:0]  d;
    } ev_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              cs_n;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_we;
    logic              reg_re;
    logic [7:0]        reg_rdata = 8'h00;
    logic              err;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         overlap = 0;
    logic [7:0] salt = 8'h00;
    logic [7:0] fdata[$];
    ev_t        obs_we[$];
    ev_t        obs_tx[$];
    ev_t        obs_re[$];

    spi_reg_ctrl #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cs_n      (cs_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] bank_val(input int a);
        return 8'(a * 17) ^ salt;
    endfunction

    // Register bank: read data appears the cycle after reg_re.
    always @(posedge clk) begin
        if (reg_re) reg_rdata <= bank_val(int'(reg_addr));
    end

    always @(negedge clk) begin
        ev_t ev;
        ev.cyc = 32'(cyc);
        if (reg_we) begin
            ev.a = 8'(reg_addr);
            ev.d = reg_wdata;
            obs_we.push_back(ev);
        end
        if (reg_re) begin
            ev.a = 8'(reg_addr);
            ev.d = 8'h00;
            obs_re.push_back(ev);
        end
        if (tx_valid) begin
            ev.a = 8'h00;
            ev.d = tx_data;
            obs_tx.push_back(ev);
        end
        if (reg_we && reg_re) overlap = overlap + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_we.delete();
        obs_tx.delete();
        obs_re.delete();
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        repeat (gap - 1) step();
    endtask

    // Drives one frame (cmd + fdata) and checks it against the frame-level model.
    task automatic run_frame(input logic [7:0] cmd, input int gap, input string tag);
        int   trig[$];
        int   a0;
        int   addr;
        bit   exp_err;
        ev_t  ev;
        ev_t  exp_we[$];
        ev_t  exp_tx[$];
        ev_t  exp_re[$];
        clear_obs();
        cs_n = 1'b0;
        step();
        step();
        trig.push_back(cyc);
        send(cmd, gap);
        foreach (fdata[i]) begin
            trig.push_back(cyc);
            send(fdata[i], gap);
        end
        step();
        step();
        cs_n = 1'b1;
        step();
        step();

        a0      = int'(cmd[6:0]);
        exp_err = (a0 >= NUM_REGS);
        if (!exp_err) begin
            if (cmd[7]) begin
                for (int k = 0; k < trig.size(); k++) begin
                    addr   = (a0 + (AUTOINC ? k : 0)) % NUM_REGS;
                    ev.cyc = 32'(trig[k] + 1);
                    ev.a   = 8'(addr);
                    ev.d   = 8'h00;
                    exp_re.push_back(ev);
                    ev.cyc = 32'(trig[k] + 3);
                    ev.a   = 8'h00;
                    ev.d   = bank_val(addr);
                    exp_tx.push_back(ev);
                end
            end else begin
                for (int k = 1; k < trig.size(); k++) begin
                    addr   = (a0 + (AUTOINC ? k - 1 : 0)) % NUM_REGS;
                    ev.cyc = 32'(trig[k] + 1);
                    ev.a   = 8'(addr);
                    ev.d   = fdata[k - 1];
                    exp_we.push_back(ev);
                end
            end
        end

        checks++;
        if (obs_we.size() !== exp_we.size()) begin
            errors++;
            $display("FAIL %s write count: got %0d want %0d", tag, obs_we.size(), exp_we.size());
        end
        for (int i = 0; i < obs_we.size() && i < exp_we.size(); i++) begin
            checks++;
            if (obs_we[i] !== exp_we[i]) begin
                errors++;
                $display("FAIL %s write[%0d]: got cyc=%0d addr=%0h data=%0h want cyc=%0d addr=%0h data=%0h",
                         tag, i, obs_we[i].cyc, obs_we[i].a, obs_we[i].d,
                         exp_we[i].cyc, exp_we[i].a, exp_we[i].d);
            end
        end
        checks++;
        if (obs_re.size() !== exp_re.size()) begin
            errors++;
            $display("FAIL %s read strobe count: got %0d want %0d", tag, obs_re.size(), exp_re.size());
        end
        for (int i = 0; i < obs_re.size() && i < exp_re.size(); i++) begin
            checks++;
            if (obs_re[i] !== exp_re[i]) begin
                errors++;
                $display("FAIL %s reg_re[%0d]: got cyc=%0d addr=%0h want cyc=%0d addr=%0h",
                         tag, i, obs_re[i].cyc, obs_re[i].a, exp_re[i].cyc, exp_re[i].a);
            end
        end
        checks++;
        if (obs_tx.size() !== exp_tx.size()) begin
            errors++;
            $display("FAIL %s tx count: got %0d want %0d", tag, obs_tx.size(), exp_tx.size());
        end
        for (int i = 0; i < obs_tx.size() && i < exp_tx.size(); i++) begin
            checks++;
            if (obs_tx[i] !== exp_tx[i]) begin
                errors++;
                $display("FAIL %s tx[%0d]: got cyc=%0d data=%0h want cyc=%0d data=%0h",
                         tag, i, obs_tx[i].cyc, obs_tx[i].d, exp_tx[i].cyc, exp_tx[i].d);
            end
        end
        if (exp_tx.size() > 0) begin
            checks++;
            if (tx_data !== exp_tx[exp_tx.size() - 1].d) begin
                errors++;
                $display("FAIL %s tx_data hold: got %0h want %0h", tag, tx_data, exp_tx[exp_tx.size() - 1].d);
            end
        end
        checks++;
        if (err !== exp_err) begin
            errors++;
            $display("FAIL %s err: got %0b want %0b", tag, err, exp_err);
        end
    endtask

    task automatic check_all_zero(input string tag);
        logic [31:0] got;
        got = {tx_data, reg_wdata, 4'(reg_addr), tx_valid, reg_we, reg_re, err};
        checks++;
        if (got !== 32'h0) begin
            errors++;
            $display("FAIL %s outputs: got tx_data=%0h wdata=%0h addr=%0h tx_valid=%0b we=%0b re=%0b err=%0b want all 0",
                     tag, tx_data, reg_wdata, reg_addr, tx_valid, reg_we, reg_re, err);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        cs_n     = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;
        step();
    endtask

    task automatic test_read();
        salt = 8'h00;
        fdata.delete();
        fdata.push_back(8'hFF);
        fdata.push_back(8'h00);
        run_frame(8'h82, 4, "read");
    endtask

    task automatic test_write();
        fdata.delete();
        fdata.push_back(8'hAA);
        fdata.push_back(8'h55);
        run_frame(8'h03, 4, "write");
    endtask

    task automatic test_wrap();
        fdata.delete();
        fdata.push_back(8'h01);
        fdata.push_back(8'h02);
        run_frame(8'h0F, 5, "wrap");
    endtask

    task automatic test_error();
        fdata.delete();
        fdata.push_back(8'h11);
        fdata.push_back(8'h22);
        run_frame(8'h20, 4, "error");
        cs_n = 1'b0;
        step();
        step();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL error clear: got %0b want 0", err);
        end
        cs_n = 1'b1;
        step();
        step();
    endtask

    task automatic test_abort();
        clear_obs();
        cs_n = 1'b0;
        step();
        step();
        send(8'h05, 4);
        send(8'h12, 4);
        rx_data  = 8'h34;
        rx_valid = 1'b1;
        cs_n     = 1'b1;
        step();
        rx_valid = 1'b0;
        step();
        step();
        checks++;
        if (obs_we.size() !== 1) begin
            errors++;
            $display("FAIL abort write count: got %0d want 1", obs_we.size());
        end else begin
            checks++;
            if (obs_we[0].a !== 8'h05 || obs_we[0].d !== 8'h12) begin
                errors++;
                $display("FAIL abort write: got addr=%0h data=%0h want addr=05 data=12", obs_we[0].a, obs_we[0].d);
            end
        end
        fdata.delete();
        fdata.push_back(8'h77);
        run_frame(8'h06, 4, "after_abort");

        // Reset while the read data is in flight: tx_valid would otherwise fire next cycle.
        salt = 8'h5A;
        clear_obs();
        cs_n = 1'b0;
        step();
        step();
        rx_data  = 8'h87;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        check_all_zero("reset_mid_read");
        rst  = 1'b0;
        cs_n = 1'b1;
        step();
        step();
        step();
        checks++;
        if (obs_tx.size() !== 0) begin
            errors++;
            $display("FAIL reset_mid_read tx count: got %0d want 0", obs_tx.size());
        end
    endtask

    task automatic test_random();
        logic [7:0] cmd;
        int         n;
        for (int f = 0; f < 20; f++) begin
            salt = 8'($urandom);
            cmd[7] = 1'($urandom);
            if ($urandom_range(4, 0) == 0) cmd[6:0] = 7'($urandom_range(127, NUM_REGS));
            else cmd[6:0] = 7'($urandom_range(NUM_REGS - 1, 0));
            n = $urandom_range(4, 1);
            fdata.delete();
            for (int i = 0; i < n; i++) fdata.push_back(8'($urandom));
            run_frame(cmd, $urandom_range(7, 4), "random");
        end
    endtask

    task automatic test_no_overlap();
        checks++;
        if (overlap !== 0) begin
            errors++;
            $display("FAIL we_re_overlap: got %0d cycles want 0", overlap);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_wrap();
        test_error();
        test_abort();
        test_random();
        test_no_overlap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
